// File: rtl/conv_pkg.sv
// Shared definitions for the 2x2 convolution datapath: pixel width, window width,
// byte-lane order inside a window word and the default frame geometry.
package conv_pkg;

   localparam int unsigned DATA_W = 8;
   localparam int unsigned WIN_W  = 4 * DATA_W;

   // Byte-lane index of each window position inside the window word
   localparam int unsigned TL = 0;
   localparam int unsigned TR = 1;
   localparam int unsigned BL = 2;
   localparam int unsigned BR = 3;

   localparam int unsigned IMG_W_DEF = 4;
   localparam int unsigned IMG_H_DEF = 4;

endpackage

// File: rtl/conv_line_buf.sv
// One-row line buffer: IMG_W-deep shift register; tap is the pixel pushed IMG_W shifts ago.
module conv_line_buf #(
   parameter int unsigned IMG_W  = 4,
   parameter int unsigned DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              shift_en,
   input  logic [DATA_W-1:0] din,
   output logic [DATA_W-1:0] tap
);

   logic [DATA_W-1:0] mem_q [IMG_W];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(IMG_W); i++) begin
            mem_q[i] <= '0;
         end
      end else if (shift_en) begin
         mem_q[0] <= din;
         for (int i = 1; i < int'(IMG_W); i++) begin
            mem_q[i] <= mem_q[i-1];
         end
      end
   end

   assign tap = mem_q[IMG_W-1];

endmodule

// File: rtl/conv_window_gen.sv
// Turns a row-major pixel stream into 2x2 window words for the convolution core,
// using a one-entry output register that can reload in the same cycle it is popped.
module conv_window_gen #(
   parameter int unsigned IMG_W  = conv_pkg::IMG_W_DEF,
   parameter int unsigned IMG_H  = conv_pkg::IMG_H_DEF,
   parameter int unsigned DATA_W = conv_pkg::DATA_W
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [DATA_W-1:0]   pix_data,
   input  logic                pix_valid,
   input  logic                pix_sof,
   output logic                pix_ready,
   output logic [4*DATA_W-1:0] win_data,
   output logic                win_valid,
   output logic                win_last,
   input  logic                win_ready,
   output logic                frame_done
);

   import conv_pkg::*;

   localparam int unsigned CW = $clog2(IMG_W);
   localparam int unsigned RW = $clog2(IMG_H);
   localparam logic [CW-1:0] COL_MAX = CW'(IMG_W - 1);
   localparam logic [RW-1:0] ROW_MAX = RW'(IMG_H - 1);

   logic [CW-1:0]       col_q, col_d, cur_col;
   logic [RW-1:0]       row_q, row_d, cur_row;
   logic [DATA_W-1:0]   prev_pix_q, prev_top_q, lb_tap;
   logic [4*DATA_W-1:0] win_d;
   logic                accept, emit, is_last;

   assign pix_ready  = !win_valid || win_ready;
   assign accept     = pix_valid && pix_ready;
   assign frame_done = win_valid && win_last && win_ready;

   always_comb begin
      // A start-of-frame pixel sits at (0,0) regardless of where the counters were
      cur_col = pix_sof ? '0 : col_q;
      cur_row = pix_sof ? '0 : row_q;
      col_d   = col_q;
      row_d   = row_q;
      if (accept) begin
         if (cur_col == COL_MAX) begin
            col_d = '0;
            row_d = (cur_row == ROW_MAX) ? '0 : cur_row + 1'b1;
         end else begin
            col_d = cur_col + 1'b1;
            row_d = cur_row;
         end
      end
      emit    = accept && (cur_col != '0) && (cur_row != '0);
      is_last = (cur_col == COL_MAX) && (cur_row == ROW_MAX);
      win_d = '0;
      win_d[TL*DATA_W +: DATA_W] = prev_top_q;
      win_d[TR*DATA_W +: DATA_W] = lb_tap;
      win_d[BL*DATA_W +: DATA_W] = prev_pix_q;
      win_d[BR*DATA_W +: DATA_W] = pix_data;
   end

   conv_line_buf #(
      .IMG_W  (IMG_W),
      .DATA_W (DATA_W)
   ) u_line_buf (
      .clk      (clk),
      .rst_n    (rst_n),
      .shift_en (accept),
      .din      (pix_data),
      .tap      (lb_tap)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         col_q      <= '0;
         row_q      <= '0;
         prev_pix_q <= '0;
         prev_top_q <= '0;
         win_data   <= '0;
         win_valid  <= 1'b0;
         win_last   <= 1'b0;
      end else begin
         col_q <= col_d;
         row_q <= row_d;
         if (accept) begin
            prev_pix_q <= pix_data;
            prev_top_q <= lb_tap;
         end
         if (emit) begin
            win_data  <= win_d;
            win_valid <= 1'b1;
            win_last  <= is_last;
         end else if (win_ready) begin
            win_valid <= 1'b0;
            win_last  <= 1'b0;
         end
      end
   end

endmodule
